// File: rtl/fp_normalize_round.sv
// fp_normalize_round
// ------------------
// Normalises and rounds a raw floating-point sum into an IEEE-754 single.
// The raw sum is captured in IDLE. SHIFT brings the hidden bit to [26],
// using at most one right shift for a carry or single-bit left shifts after
// cancellation. ROUND applies round-to-nearest-even and packs the result.
// DONE holds the result until the consumer takes it.
//
// Build option:
//   FP_NORM_SUBNORMAL_EN - when defined, tiny results are denormalised and
//                          encoded as subnormals. When undefined, tiny results
//                          flush to signed zero with underflow/zero/inexact.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (ready only in IDLE, out of reset)
//   in_sign/in_exp/in_mant raw sum: sign, signed biased exponent, and a
//                          28-bit significand {carry, hidden, frac[22:0], G, R, S}
//   out_valid/out_ready   output handshake
//   out_result            packed single-precision result
//   out_overflow/out_underflow/out_inexact/out_zero  status flags
module fp_normalize_round #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [27:0]      in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact,
    output logic             out_zero
);

    // Two guard bits let exp+1 and the rounding carry never wrap.
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'(255);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Round-to-nearest-even increment decision.
    function automatic logic rne_increment(input logic g, input logic r,
                                           input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

    state_t                 state_r, state_s;
    logic                   sign_r, sign_s;
    logic signed [XW-1:0]   exp_r, exp_s;
    logic [27:0]            mant_r, mant_s;
    logic                   tiny_r, tiny_s;
    logic                   valid_r, valid_s;
    logic [31:0]            result_r, result_s;
    logic                   ovf_r, ovf_s;
    logic                   unf_r, unf_s;
    logic                   inx_r, inx_s;
    logic                   zero_r, zero_s;

    logic                   grs_s;
    logic                   inc_s;
    logic [24:0]            sum_s;
    logic [23:0]            rsig_s;
    logic signed [XW-1:0]   rexp_s;

    // Rounding of the current significand register (consumed in ROUND).
    always_comb begin
        grs_s  = mant_r[2] | mant_r[1] | mant_r[0];
        inc_s  = rne_increment(mant_r[2], mant_r[1], mant_r[0], mant_r[3]);
        sum_s  = {1'b0, mant_r[26:3]} + {24'd0, inc_s};
        if (sum_s[24]) begin
            // Rounding carried to 2^24: renormalise, exponent moves up.
            rsig_s = sum_s[24:1];
            rexp_s = exp_r + EXP_ONE;
        end else begin
            rsig_s = sum_s[23:0];
            rexp_s = exp_r;
        end
    end

    // Next-state and datapath update for the FSM.
    always_comb begin
        state_s  = state_r;
        sign_s   = sign_r;
        exp_s    = exp_r;
        mant_s   = mant_r;
        tiny_s   = tiny_r;
        valid_s  = valid_r;
        result_s = result_r;
        ovf_s    = ovf_r;
        unf_s    = unf_r;
        inx_s    = inx_r;
        zero_s   = zero_r;

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    sign_s = in_sign;
                    exp_s  = {{2{in_exp[EXP_W-1]}}, in_exp};
                    mant_s = in_mant;
                    tiny_s = 1'b0;
                    if (in_mant == 28'd0) begin
                        // Exact zero bypasses normalisation entirely.
                        result_s = {in_sign, 31'd0};
                        ovf_s    = 1'b0;
                        unf_s    = 1'b0;
                        inx_s    = 1'b0;
                        zero_s   = 1'b1;
                        valid_s  = 1'b1;
                        state_s  = DONE;
                    end else begin
                        state_s  = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            SHIFT: begin
`ifdef FP_NORM_SUBNORMAL_EN
                if (exp_r < EXP_ONE) begin
                    // Denormalise one place per cycle up to exp==1.
                    mant_s = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                    exp_s  = exp_r + EXP_ONE;
                end else
`else
                if (exp_r < EXP_ONE) begin
                    tiny_s  = 1'b1;
                    state_s = ROUND;
                end else
`endif
                if (mant_r[27]) begin
                    // Carry out: shift right, keep the lost bit in sticky.
                    mant_s  = {1'b0, mant_r[27:2], mant_r[1] | mant_r[0]};
                    exp_s   = exp_r + EXP_ONE;
                    state_s = ROUND;
                end else if (mant_r[26]) begin
                    state_s = ROUND;
                end else if (exp_r > EXP_ONE) begin
                    mant_s  = {mant_r[26:0], 1'b0};
                    exp_s   = exp_r - EXP_ONE;
                end else begin
                    // exp==1 with no hidden bit: the value is tiny.
                    tiny_s  = 1'b1;
                    state_s = ROUND;
                end
            end

            ROUND: begin
                valid_s = 1'b1;
                state_s = DONE;
                ovf_s   = 1'b0;
                zero_s  = 1'b0;
`ifdef FP_NORM_SUBNORMAL_EN
                unf_s   = tiny_r & grs_s;
                inx_s   = grs_s;
                if (rexp_s >= EXP_MAX) begin
                    result_s = {sign_r, 8'hFF, 23'd0};
                    ovf_s    = 1'b1;
                    inx_s    = 1'b1;
                end else begin
                    // Hidden bit clear means subnormal: exponent field 0.
                    result_s = {sign_r, (rsig_s[23] ? rexp_s[7:0] : 8'd0), rsig_s[22:0]};
                    zero_s   = (rsig_s == 24'd0);
                end
`else
                if (tiny_r) begin
                    result_s = {sign_r, 31'd0};
                    unf_s    = 1'b1;
                    inx_s    = 1'b1;
                    zero_s   = 1'b1;
                end else if (rexp_s >= EXP_MAX) begin
                    result_s = {sign_r, 8'hFF, 23'd0};
                    unf_s    = 1'b0;
                    ovf_s    = 1'b1;
                    inx_s    = 1'b1;
                end else begin
                    result_s = {sign_r, (rsig_s[23] ? rexp_s[7:0] : 8'd0), rsig_s[22:0]};
                    unf_s    = 1'b0;
                    inx_s    = grs_s;
                end
`endif
            end

            DONE: begin
                if (out_ready) begin
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end

            default: begin
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r   <= 1'b0;
            exp_r    <= '0;
            mant_r   <= 28'd0;
            tiny_r   <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= 32'd0;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            inx_r    <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            sign_r   <= sign_s;
            exp_r    <= exp_s;
            mant_r   <= mant_s;
            tiny_r   <= tiny_s;
            valid_r  <= valid_s;
            result_r <= result_s;
            ovf_r    <= ovf_s;
            unf_r    <= unf_s;
            inx_r    <= inx_s;
            zero_r   <= zero_s;
        end
    end

    // rst_n gating keeps in_ready low throughout reset, high right after it.
    assign in_ready      = rst_n & (state_r == IDLE);
    assign out_valid     = valid_r;
    assign out_result    = result_r;
    assign out_overflow  = ovf_r;
    assign out_underflow = unf_r;
    assign out_inexact   = inx_r;
    assign out_zero      = zero_r;

endmodule
